// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: 16-byte register window, byte FIFO, 8N1 serialiser; MMIO_UART_TX_IRQ_EN adds CTRL and tx_irq.
// Stores act at the clk edge, loads are combinational; a push into a full FIFO is dropped and sets sticky OVF.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write_en,
  input  logic [2:0]  s_type,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  l_type,
  output logic [31:0] mem_rdata,
  output logic        sel,
  output logic        tx
`ifdef MMIO_UART_TX_IRQ_EN
  ,
  output logic        tx_irq
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_BAUD   = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  logic [1:0]    off;
  logic          st_ok;
  logic          wr;
  logic          push;
  logic          push_ok;
  logic          pop;
  logic          div_wr;
  logic          ovf_clr;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          ovf;
  logic [7:0]    head;
  logic [3:0]    cnt4;

  logic [15:0]   baud_div;
  logic [15:0]   div_eff;

  logic [1:0]    state;
  logic [15:0]   bit_div;
  logic [15:0]   div_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          bit_end;
  logic          busy;

  logic [31:0]   raw;
  logic [31:0]   fmt;
  logic          unused_bits;

  assign sel     = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign off     = mem_addr[3:2];
  assign st_ok   = (s_type == SB) || (s_type == SH) || (s_type == SW);
  assign wr      = sel && mem_write_en && st_ok;
  assign push    = wr && (off == OFF_TXDATA);
  assign push_ok = push && !full;
  assign div_wr  = wr && (off == OFF_BAUD) && (s_type != SB);
  assign ovf_clr = wr && (off == OFF_STATUS) && mem_wdata[3];

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign head  = fifo_mem[rd_ptr];
  assign cnt4  = 4'(count);

  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:16]};

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= mem_wdata[7:0];
    end
  end

  // Full is judged before any same-cycle pop, so a push at full is always lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push_ok) - CW'(pop);
      if (push && full) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_div <= DEFAULT_DIV;
    end else if (div_wr) begin
      baud_div <= mem_wdata[15:0];
    end
  end

  assign div_eff = (baud_div == 16'd0) ? 16'd1 : baud_div;
  assign bit_end = (div_cnt == bit_div - 16'd1);
  assign busy    = (state != ST_IDLE);
  assign pop     = !empty && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      bit_div <= 16'd1;
      div_cnt <= 16'd0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      tx      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shift   <= head;
            bit_div <= div_eff;
            div_cnt <= 16'd0;
            state   <= ST_START;
            tx      <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            div_cnt <= 16'd0;
            bit_idx <= 3'd0;
            state   <= ST_DATA;
            tx      <= shift[0];
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            div_cnt <= 16'd0;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            div_cnt <= 16'd0;
            // Chain straight into the next start bit when more data is queued.
            if (pop) begin
              shift   <= head;
              bit_div <= div_eff;
              state   <= ST_START;
              tx      <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

`ifdef MMIO_UART_TX_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en <= 1'b0;
      tx_irq <= 1'b0;
    end else begin
      if (wr && (off == OFF_CTRL)) begin
        irq_en <= mem_wdata[0];
      end
      tx_irq <= irq_en && empty && !busy;
    end
  end
`endif

  always_comb begin
    raw = 32'd0;
    case (off)
      OFF_STATUS: raw = {24'd0, cnt4, ovf, busy, empty, full};
      OFF_BAUD:   raw = {16'd0, baud_div};
`ifdef MMIO_UART_TX_IRQ_EN
      OFF_CTRL:   raw = {31'd0, irq_en};
`endif
      default:    raw = 32'd0;
    endcase
  end

  always_comb begin
    fmt = 32'd0;
    case (l_type)
      3'b000:  fmt = {{24{raw[7]}}, raw[7:0]};
      3'b001:  fmt = {{16{raw[15]}}, raw[15:0]};
      3'b010:  fmt = raw;
      3'b100:  fmt = {24'd0, raw[7:0]};
      3'b101:  fmt = {16'd0, raw[15:0]};
      default: fmt = 32'd0;
    endcase
  end

  assign mem_rdata = sel ? fmt : 32'd0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register decode, load formatting, FIFO overflow and tx frame timing.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk;
  logic        reset;
  logic        mem_write_en;
  logic [2:0]  s_type;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  l_type;
  logic [31:0] mem_rdata;
  logic        sel;
  logic        tx;
`ifdef MMIO_UART_TX_IRQ_EN
  logic        tx_irq;
`endif

  int tests = 0;
  int fails = 0;

  mmio_uart_tx dut (
    .clk          (clk),
    .reset        (reset),
    .mem_write_en (mem_write_en),
    .s_type       (s_type),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .l_type       (l_type),
    .mem_rdata    (mem_rdata),
    .sel          (sel),
    .tx           (tx)
`ifdef MMIO_UART_TX_IRQ_EN
    ,
    .tx_irq       (tx_irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Store lands on the next rising edge; returns 1ns after that edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] st);
    @(negedge clk);
    mem_addr     = a;
    mem_wdata    = d;
    s_type       = st;
    mem_write_en = 1'b1;
    @(posedge clk);
    #1;
    mem_write_en = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] lt, output logic [31:0] d);
    mem_addr = a;
    l_type   = lt;
    #1;
    d = mem_rdata;
  endtask

  // Expected tx level per cycle of one 8N1 frame, bit i = cycle i.
  function automatic logic [63:0] frame(input logic [7:0] b, input int div);
    logic [63:0] f;
    int          k;
    f = '0;
    for (int i = 0; i < div * 10; i++) begin
      k = i / div;
      if (k == 0)      f[i] = 1'b0;
      else if (k == 9) f[i] = 1'b1;
      else             f[i] = b[k-1];
    end
    return f;
  endfunction

  initial begin
    logic [31:0] rd;
    logic [63:0] got;
    logic        all_high;

    reset        = 1'b0;
    mem_write_en = 1'b0;
    s_type       = 3'b000;
    mem_addr     = BASE;
    mem_wdata    = 32'd0;
    l_type       = 3'b010;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // reset state
    #1;
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_sel", 64'(sel), 64'd1);
    load(BASE + 32'h4, 3'b010, rd); check("rst_status", 64'(rd), 64'h02);
    load(BASE + 32'h8, 3'b010, rd); check("rst_baud", 64'(rd), 64'd868);
    load(BASE + 32'h0, 3'b010, rd); check("txdata_rd", 64'(rd), 64'd0);
    load(BASE + 32'hC, 3'b010, rd); check("rst_ctrl", 64'(rd), 64'd0);
`ifdef MMIO_UART_TX_IRQ_EN
    check("rst_irq", 64'(tx_irq), 64'd0);
`endif

    // single byte, div 4
    store(BASE + 32'h8, 32'd4, 3'b010);
    store(BASE + 32'h0, 32'h55, 3'b000);
    check("pre_start", 64'(tx), 64'd1);
    got = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      got[i] = tx;
    end
    check("frame55", got, frame(8'h55, 4));
    @(posedge clk); #1;
    check("idle55_tx", 64'(tx), 64'd1);
    load(BASE + 32'h4, 3'b010, rd); check("idle55_status", 64'(rd), 64'h02);

    // back-to-back frames, div 2
    store(BASE + 32'h8, 32'd2, 3'b001);
    store(BASE + 32'h0, 32'h1234_5641, 3'b010);
    store(BASE + 32'h0, 32'h42, 3'b010);
    got = '0;
    got[0] = tx;
    for (int i = 1; i < 40; i++) begin
      @(posedge clk); #1;
      got[i] = tx;
    end
    check("b2b_frames", got, (frame(8'h42, 2) << 20) | frame(8'h41, 2));
    repeat (2) @(posedge clk); #1;
    load(BASE + 32'h4, 3'b010, rd); check("b2b_status", 64'(rd), 64'h02);

    // load formatting
    store(BASE + 32'h8, 32'h0000_FF80, 3'b010);
    load(BASE + 32'h8, 3'b000, rd); check("lb", 64'(rd), 64'hFFFF_FF80);
    load(BASE + 32'h8, 3'b100, rd); check("lbu", 64'(rd), 64'h0000_0080);
    load(BASE + 32'h8, 3'b001, rd); check("lh", 64'(rd), 64'hFFFF_FF80);
    load(BASE + 32'h8, 3'b101, rd); check("lhu", 64'(rd), 64'h0000_FF80);
    load(BASE + 32'hA, 3'b010, rd); check("lw_lowbits", 64'(rd), 64'h0000_FF80);
    load(BASE + 32'h8, 3'b011, rd); check("lt_undef", 64'(rd), 64'd0);
    load(BASE + 32'h10, 3'b010, rd);
    check("miss_sel", 64'(sel), 64'd0);
    check("miss_rdata", 64'(rd), 64'd0);
    store(BASE + 32'h8, 32'h12, 3'b000);
    load(BASE + 32'h8, 3'b010, rd); check("sb_baud_ign", 64'(rd), 64'h0000_FF80);
    store(BASE + 32'h8, 32'h12, 3'b011);
    load(BASE + 32'h8, 3'b010, rd); check("st_undef_ign", 64'(rd), 64'h0000_FF80);

    // overflow, div 100
    store(BASE + 32'h8, 32'd100, 3'b010);
    for (int i = 0; i < 10; i++) begin
      store(BASE + 32'h0, 32'(8'h60 + i), 3'b000);
    end
    load(BASE + 32'h4, 3'b100, rd); check("ovf_lbu", 64'(rd), 64'h8D);
    load(BASE + 32'h4, 3'b000, rd); check("ovf_lb", 64'(rd), 64'hFFFF_FF8D);
    store(BASE + 32'h4, 32'h8, 3'b010);
    load(BASE + 32'h4, 3'b010, rd); check("ovf_clear", 64'(rd), 64'h85);

    // reset mid-frame
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    store(BASE + 32'h8, 32'd4, 3'b010);
    store(BASE + 32'h0, 32'hA5, 3'b000);
    repeat (9) @(posedge clk);
    #1;
    check("a5_bit1", 64'(tx), 64'd0);
    #2;
    reset = 1'b0;
    #1;
    check("async_tx", 64'(tx), 64'd1);
    load(BASE + 32'h4, 3'b010, rd); check("inrst_status", 64'(rd), 64'h02);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    load(BASE + 32'h8, 3'b010, rd); check("post_baud", 64'(rd), 64'd868);
    all_high = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      all_high = all_high & tx;
    end
    check("abandoned", 64'(all_high), 64'd1);
    load(BASE + 32'h4, 3'b010, rd); check("post_status", 64'(rd), 64'h02);

    // CTRL / interrupt
    store(BASE + 32'h8, 32'd2, 3'b010);
    store(BASE + 32'hC, 32'd1, 3'b000);
    load(BASE + 32'hC, 3'b010, rd);
`ifdef MMIO_UART_TX_IRQ_EN
    check("ctrl_rd", 64'(rd), 64'd1);
    @(posedge clk); #1;
    check("irq_idle", 64'(tx_irq), 64'd1);
    store(BASE + 32'h0, 32'h3C, 3'b000);
    @(posedge clk); #1;
    check("irq_fall", 64'(tx_irq), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    check("irq_stop_end", 64'(tx_irq), 64'd0);
    @(posedge clk); #1;
    check("irq_rise", 64'(tx_irq), 64'd1);
`else
    check("ctrl_rd", 64'(rd), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped responder on the core's data-memory bus (store/load type codes, address, write data, read data); sits beside the data memory and answers a 16-byte address window.
- Stores are taken as transmit bytes or configuration; loads return status.
- Transmit bytes are buffered in a FIFO and serialised as 8N1 UART frames on `tx`.

Parameters:
- BASE_ADDR, 32'h1000_0000, word-aligned base of the 16-byte register window.
- FIFO_DEPTH, 8, transmit FIFO entries; power of two, 2..64.
- DEFAULT_DIV, 16'd868, reset value of BAUD_DIV (clk cycles per UART bit).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- mem_write_en  in  1  store strobe from core, sampled at clk edge.
- s_type  in  3  store width: 000 SB, 001 SH, 010 SW.
- mem_addr  in  32  byte address (ALU result).
- mem_wdata  in  32  store data.
- l_type  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_rdata  out  32  combinational load data; 0 when the address is outside the window.
- sel  out  1  combinational; high when mem_addr[31:4] == BASE_ADDR[31:4].
- tx  out  1  UART serial output, idle high, registered.

Behaviour:
- Address decode
  - Hit = `sel`. Register offset = mem_addr[3:2]; mem_addr[1:0] is ignored.
  - Offsets: 0x0 TXDATA (W), 0x4 STATUS (R/W1C), 0x8 BAUD_DIV (R/W), 0xC CTRL.
- Stores (hit and mem_write_en at clk edge)
  - TXDATA: mem_wdata[7:0] is pushed for any s_type.
  - BAUD_DIV: SW/SH load BAUD_DIV[15:0] from mem_wdata[15:0]; SB ignored.
  - STATUS: writing 1 to bit3 clears OVF; all other bits ignored.
  - Stores with an undefined s_type (011..111) are ignored.
- Loads
  - Raw word: STATUS = {24'b0, count[3:0], OVF, busy, empty, full}. BAUD_DIV = {16'b0, div}. TXDATA = 0.
  - l_type applied to the raw word: LB/LBU sign/zero-extend bits[7:0]; LH/LHU sign/zero-extend bits[15:0]; LW full word; undefined codes return 0.
- FIFO
  - count width log2(FIFO_DEPTH)+1; full = (count == FIFO_DEPTH); empty = (count == 0).
  - A push with full = 1 is dropped and sets sticky OVF. This holds even when the TX FSM pops in the same cycle.
  - A push and a pop in the same cycle with count < FIFO_DEPTH leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if !empty, pop the head into the shift register, latch bit_div = max(BAUD_DIV, 1) and go to START; tx = 0 from that edge on. A byte pushed at edge N therefore drives tx low after edge N+1.
  - START: tx = 0 for bit_div cycles, then DATA.
  - DATA: 8 bits LSB first, bit_div cycles each.
  - STOP: tx = 1 for bit_div cycles. At the end, if !empty, pop and enter START directly (no idle gap); else go to IDLE.
  - busy = (state != IDLE).
  - BAUD_DIV writes mid-frame affect only the next frame.
- Reset (asynchronous, active-low, may hit mid-frame)
  - tx = 1, state IDLE, FIFO emptied, OVF = 0, BAUD_DIV = DEFAULT_DIV, bit counters 0.
  - Any partial frame is abandoned.

Optional Feature:
- MMIO_UART_TX_IRQ_EN defined:
  - Adds output port tx_irq (1 bit, registered, reset 0).
  - CTRL bit0 = IRQ enable (reset 0, written by SW/SH/SB via mem_wdata[0], readable).
  - tx_irq = enable & empty & !busy, updated every cycle.
- Not defined: no tx_irq port; CTRL reads 0 and writes are ignored.

Test Plan:
- Reset: reset low mid-frame (BAUD_DIV=4, 0xA5 in flight) -> tx = 1 immediately; STATUS reads 0x02; BAUD_DIV reads 868 after reset release.
- Single byte: SW 4 to 0x8, SB 0x55 to 0x0 -> tx low for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles. Frame length 40 cycles; first falling edge 1 cycle after the store edge.
- Back-to-back: BAUD_DIV=2, SW 0x1234_5641 then 0x42 to 0x0 -> two frames with no idle between stop and start; only the low bytes 0x41 and 0x42 are sent.
- Overflow: BAUD_DIV=100, push 10 bytes in consecutive cycles (FIFO_DEPTH 8) -> first byte popped, 8 queued, last dropped. STATUS LBU returns count=8, full=1, OVF=1, busy=1. SW 0x8 to 0x4 clears OVF only.
- Load types: BAUD_DIV=16'hFF80 -> LB at 0x8 = 0xFFFF_FF80, LBU = 0x0000_0080, LH = 0xFFFF_FF80, LHU = 0x0000_FF80. Load at BASE_ADDR+0x10 -> sel=0, mem_rdata=0. SB to 0x8 leaves the value unchanged.
- IRQ (macro defined): SB 1 to 0xC with FIFO idle -> tx_irq=1. Push a byte -> tx_irq falls within 1 cycle; it returns to 1 one cycle after the STOP bit ends.
